// File: rtl/cmd_resp_pkg.sv
// cmd_responder shared types, default bytes and opcode table.
// Imported by the responder top and its bench.
package cmd_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    EXEC,
    SEND,
    WAIT_TX
  } resp_state_t;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  localparam logic [7:0] NAK_DEFAULT = 8'h5A;

  // bit n set => opcode n accepted (4'h0..4'h7)
  localparam logic [15:0] LEGAL_OPC_MASK = 16'h00FF;

  function automatic logic is_legal_opcode(
    input logic [3:0] op
  );
    return LEGAL_OPC_MASK[op];
  endfunction

endpackage

// File: rtl/cmd_responder_if.sv
// cmd_responder bus: UART_wrapper side and consumer side.
// slave = responder, master = wrapper/consumer.
interface cmd_responder_if;

  logic        cmd_rdy;
  logic [15:0] cmd;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;
  logic [15:0] cmd_out;
  logic        cmd_vld;
  logic        cmd_ack;
  logic        cmd_done;
  logic        cmd_err;
  logic        busy;

  modport slave (
    input  cmd_rdy,
    input  cmd,
    input  tx_done,
    input  cmd_ack,
    input  cmd_done,
    input  cmd_err,
    output clr_cmd_rdy,
    output trmt,
    output resp,
    output cmd_out,
    output cmd_vld,
    output busy
  );

  modport master (
    output cmd_rdy,
    output cmd,
    output tx_done,
    output cmd_ack,
    output cmd_done,
    output cmd_err,
    input  clr_cmd_rdy,
    input  trmt,
    input  resp,
    input  cmd_out,
    input  cmd_vld,
    input  busy
  );

endinterface

// File: rtl/resp_timeout_cnt.sv
// Execution watchdog: clear/enable counter, expired at TIMEOUT_CYC-1.
// Holds at the last value so it can never wrap.
module resp_timeout_cnt #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_cnt;

  // count while enabled, restart on clear
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en && !o_expired)
      r_cnt <= r_cnt + TO_W'(1);
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/cmd_responder.sv
// Responder command sequencer: latch, forward, await, ACK/NAK.
// Optional opcode filter: define CMD_OPCODE_CHECK_EN.
module cmd_responder
  import cmd_resp_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE    = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE    = NAK_DEFAULT,
  parameter int         TIMEOUT_CYC = 5_000_000
) (
  input logic           clk,
  input logic           rst_n,
  cmd_responder_if.slave bus
);

  resp_state_t r_state;
  resp_state_t w_state_nxt;

  logic        r_clr;
  logic        r_trmt;
  logic [7:0]  r_resp;
  logic [15:0] r_cmd_out;
  logic        r_vld;
  logic        r_busy;

  logic        w_clr_nxt;
  logic        w_trmt_nxt;
  logic [7:0]  w_resp_nxt;
  logic [15:0] w_cmd_out_nxt;
  logic        w_vld_nxt;
  logic        w_busy_nxt;

  logic        w_to_clr;
  logic        w_to_en;
  logic        w_expired;
  logic        w_legal;

`ifdef CMD_OPCODE_CHECK_EN
  assign w_legal = is_legal_opcode(bus.cmd[15:12]);
`else
  assign w_legal = 1'b1;
`endif

  resp_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_to (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_to_clr),
    .i_en     (w_to_en),
    .o_expired(w_expired)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // next state and next registered outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_nxt     = 1'b0;
    w_resp_nxt    = r_resp;
    w_cmd_out_nxt = r_cmd_out;
    w_vld_nxt     = r_vld;
    w_to_clr      = 1'b0;
    w_to_en       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.cmd_rdy) begin
          w_clr_nxt = 1'b1;
          if (w_legal) begin
            w_cmd_out_nxt = bus.cmd;
            w_vld_nxt     = 1'b1;
            w_state_nxt   = ISSUE;
          end else begin
            w_resp_nxt  = NAK_BYTE;
            w_state_nxt = SEND;
          end
        end
      end
      ISSUE: begin
        if (bus.cmd_ack) begin
          w_vld_nxt   = 1'b0;
          w_to_clr    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_to_en = 1'b1;
        if (bus.cmd_err) begin
          w_resp_nxt  = NAK_BYTE;
          w_state_nxt = SEND;
        end else if (bus.cmd_done) begin
          w_resp_nxt  = ACK_BYTE;
          w_state_nxt = SEND;
        end else if (w_expired) begin
          w_resp_nxt  = NAK_BYTE;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.tx_done)
          w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_trmt_nxt = (w_state_nxt == SEND);
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr     <= 1'b0;
      r_trmt    <= 1'b0;
      r_resp    <= 8'h00;
      r_cmd_out <= 16'h0000;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_clr     <= w_clr_nxt;
      r_trmt    <= w_trmt_nxt;
      r_resp    <= w_resp_nxt;
      r_cmd_out <= w_cmd_out_nxt;
      r_vld     <= w_vld_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign bus.clr_cmd_rdy = r_clr;
  assign bus.trmt        = r_trmt;
  assign bus.resp        = r_resp;
  assign bus.cmd_out     = r_cmd_out;
  assign bus.cmd_vld     = r_vld;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder (TIMEOUT_CYC=50).
// Wrapper and consumer are driven by hand.
module tb_cmd_responder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cmd_responder_if bus();

  cmd_responder #(
    .ACK_BYTE   (8'hA5),
    .NAK_BYTE   (8'h5A),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_trmt = 0;
  int n_clr  = 0;
  logic [7:0] resp_log[$];

  always @(negedge clk) begin
    if (bus.trmt) begin
      n_trmt++;
      resp_log.push_back(bus.resp);
    end
    if (bus.clr_cmd_rdy)
      n_clr++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [15:0] c);
    bus.cmd     = c;
    bus.cmd_rdy = 1'b1;
    tick();
    bus.cmd_rdy = 1'b0;
  endtask

  task automatic do_ack();
    bus.cmd_ack = 1'b1;
    tick();
    bus.cmd_ack = 1'b0;
  endtask

  task automatic finish_tx();
    tick(2);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_clr"},  bus.clr_cmd_rdy, 0);
    chk({tag, "_trmt"}, bus.trmt, 0);
    chk({tag, "_resp"}, bus.resp, 8'h00);
    chk({tag, "_cout"}, bus.cmd_out, 16'h0000);
    chk({tag, "_vld"},  bus.cmd_vld, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int n;
    int base;
    rst_n        = 1'b0;
    bus.cmd_rdy  = 1'b0;
    bus.cmd      = 16'h0000;
    bus.tx_done  = 1'b0;
    bus.cmd_ack  = 1'b0;
    bus.cmd_done = 1'b0;
    bus.cmd_err  = 1'b0;
    tick(2);
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // success, done during ack cycle must be ignored
    send_cmd(16'h1234);
    chk("t1_clr1", bus.clr_cmd_rdy, 1);
    chk("t1_vld1", bus.cmd_vld, 1);
    chk("t1_cout", bus.cmd_out, 16'h1234);
    chk("t1_busy", bus.busy, 1);
    tick();
    chk("t1_clr0", bus.clr_cmd_rdy, 0);
    chk("t1_vldh", bus.cmd_vld, 1);
    tick();
    bus.cmd_ack  = 1'b1;
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_ack  = 1'b0;
    bus.cmd_done = 1'b0;
    chk("t1_vld0", bus.cmd_vld, 0);
    chk("t1_noearly", bus.trmt, 0);
    chk("t1_couth", bus.cmd_out, 16'h1234);
    tick(9);
    chk("t1_wait", bus.trmt, 0);
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    chk("t1_trmt", bus.trmt, 1);
    chk("t1_ack", bus.resp, 8'hA5);
    tick();
    chk("t1_trmt0", bus.trmt, 0);
    chk("t1_hold", bus.resp, 8'hA5);
    chk("t1_wbusy", bus.busy, 1);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("t1_idle", bus.busy, 0);
    chk("t1_ntrmt", n_trmt, 1);
    chk("t1_nclr", n_clr, 1);

    // error, stray tx_done in EXEC ignored
    send_cmd(16'h2F82);
    do_ack();
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("t2_busy", bus.busy, 1);
    chk("t2_notx", bus.trmt, 0);
    tick();
    bus.cmd_err = 1'b1;
    tick();
    bus.cmd_err = 1'b0;
    chk("t2_trmt", bus.trmt, 1);
    chk("t2_nak", bus.resp, 8'h5A);
    finish_tx();
    chk("t2_idle", bus.busy, 0);
    chk("t2_ntrmt", n_trmt, 2);

    // timeout: trmt 50 cycles after leaving ISSUE
    send_cmd(16'h3001);
    do_ack();
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (bus.trmt)
        break;
    end
    chk("t3_cycles", n, 50);
    chk("t3_nak", bus.resp, 8'h5A);
    finish_tx();

    // done on the expiry cycle wins
    send_cmd(16'h0700);
    do_ack();
    tick(49);
    chk("t4_pre", bus.trmt, 0);
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    chk("t4_trmt", bus.trmt, 1);
    chk("t4_ack", bus.resp, 8'hA5);
    finish_tx();

    // back-to-back: second cmd held during WAIT_TX
    send_cmd(16'h1111);
    do_ack();
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    chk("t5_trmt1", bus.trmt, 1);
    tick();
    base = n_clr;
    bus.cmd     = 16'h4002;
    bus.cmd_rdy = 1'b1;
    tick(3);
    chk("t5_noclr", n_clr, base);
    chk("t5_held", bus.cmd_out, 16'h1111);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("t5_idle", bus.busy, 0);
    chk("t5_clr0", bus.clr_cmd_rdy, 0);
    tick();
    bus.cmd_rdy = 1'b0;
    chk("t5_clr1", bus.clr_cmd_rdy, 1);
    chk("t5_cout", bus.cmd_out, 16'h4002);
    chk("t5_vld", bus.cmd_vld, 1);
    do_ack();
    bus.cmd_err = 1'b1;
    tick();
    bus.cmd_err = 1'b0;
    chk("t5_trmt2", bus.trmt, 1);
    finish_tx();
    chk("t5_ntrmt", n_trmt, 6);
    chk("t5_ord1", resp_log[4], 8'hA5);
    chk("t5_ord2", resp_log[5], 8'h5A);

    // done and err together -> NAK
    send_cmd(16'h5555);
    do_ack();
    bus.cmd_done = 1'b1;
    bus.cmd_err  = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    bus.cmd_err  = 1'b0;
    chk("t6_trmt", bus.trmt, 1);
    chk("t6_nak", bus.resp, 8'h5A);
    finish_tx();

    // reset in EXEC aborts without response
    send_cmd(16'h6006);
    do_ack();
    tick(2);
    base = n_trmt;
    rst_n = 1'b0;
    tick();
    chk_reset("t7");
    rst_n = 1'b1;
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    tick(3);
    chk("t7_notrmt", n_trmt, base);
    chk("t7_idle", bus.busy, 0);

`ifdef CMD_OPCODE_CHECK_EN
    send_cmd(16'hF000);
    chk("t8_clr", bus.clr_cmd_rdy, 1);
    chk("t8_vld", bus.cmd_vld, 0);
    chk("t8_trmt", bus.trmt, 1);
    chk("t8_nak", bus.resp, 8'h5A);
    chk("t8_cout", bus.cmd_out, 16'h0000);
    finish_tx();
    send_cmd(16'h1000);
    chk("t8_fwd", bus.cmd_vld, 1);
    chk("t8_fcout", bus.cmd_out, 16'h1000);
    do_ack();
    bus.cmd_done = 1'b1;
    tick();
    bus.cmd_done = 1'b0;
    chk("t8_ack", bus.resp, 8'hA5);
    finish_tx();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
